tick_countdown: RTL

TICK_COUNTDOWN -- requirements
Module: tick_countdown

---
 rtl/tick_countdown_pkg.sv | 41 ++++
 rtl/bcd_mmss_dec.sv | 31 +++
 rtl/tick_countdown.sv | 103 ++++++++++
 3 files changed

// File: rtl/tick_countdown_pkg.sv
// Shared types and constants for the mm:ss BCD countdown timer.
// Optional low-time warning is enabled by defining TICK_COUNTDOWN_WARN_EN.
package tick_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t min_hi;
    bcd_digit_t min_lo;
    bcd_digit_t sec_hi;
    bcd_digit_t sec_lo;
  } mmss_t;

  localparam logic [7:0] SEC_MAX_BCD = 8'h59;
  localparam bcd_digit_t DIGIT_MAX   = 4'h9;
  localparam logic [7:0] WARN_THRESH = 8'h10;

  function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

  // Digits are clamped first so the seconds range check compares valid BCD.
  function automatic mmss_t clamp_load(input logic [7:0] mm, input logic [7:0] ss);
    mmss_t      r;
    logic [7:0] s;
    r.min_hi = clamp_digit(mm[7:4]);
    r.min_lo = clamp_digit(mm[3:0]);
    s = {clamp_digit(ss[7:4]), clamp_digit(ss[3:0])};
    if (s > SEC_MAX_BCD) s = SEC_MAX_BCD;
    {r.sec_hi, r.sec_lo} = s;
    return r;
  endfunction

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second BCD decrement of mm:ss; saturates at 00:00.
// zero flags that the decremented result is 00:00.
module bcd_mmss_dec
  import tick_countdown_pkg::*;
(
  input  mmss_t cur,
  output mmss_t nxt,
  output logic  zero
);

  always_comb begin
    nxt = cur;
    if (cur.sec_lo != 4'd0) begin
      nxt.sec_lo = cur.sec_lo - 4'd1;
    end else if (cur.sec_hi != 4'd0) begin
      nxt.sec_hi = cur.sec_hi - 4'd1;
      nxt.sec_lo = DIGIT_MAX;
    end else if ({cur.min_hi, cur.min_lo} != 8'h00) begin
      {nxt.sec_hi, nxt.sec_lo} = SEC_MAX_BCD;
      if (cur.min_lo != 4'd0) begin
        nxt.min_lo = cur.min_lo - 4'd1;
      end else begin
        nxt.min_hi = cur.min_hi - 4'd1;
        nxt.min_lo = DIGIT_MAX;
      end
    end
  end

  assign zero = (nxt == '0);

endmodule

// File: rtl/tick_countdown.sv
// mm:ss BCD countdown timer driven by an external tick strobe with a prescaler.
// Define TICK_COUNTDOWN_WARN_EN to enable the low-time warn output.
module tick_countdown
  import tick_countdown_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       warn
);

  localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_STEP - 1);

  state_t     state, state_n;
  mmss_t      count, count_n, count_dec;
  logic       dec_zero;
  logic [7:0] presc, presc_n;
  logic       expired_n;

  bcd_mmss_dec u_dec (
    .cur  (count),
    .nxt  (count_dec),
    .zero (dec_zero)
  );

  // One action per cycle, in priority order load > stop > start > tick.
  // A start that is ignored (RUN) does not block a tick.
  always_comb begin
    state_n   = state;
    count_n   = count;
    presc_n   = presc;
    expired_n = 1'b0;
    if (load) begin
      count_n = clamp_load(load_min, load_sec);
      presc_n = '0;
      state_n = ST_IDLE;
    end else if (stop) begin
      if (state == ST_RUN) state_n = ST_PAUSE;
    end else if (start && state == ST_IDLE) begin
      if (count != '0) state_n = ST_RUN;
    end else if (start && state == ST_PAUSE) begin
      state_n = ST_RUN;
    end else if (tick && state == ST_RUN) begin
      if (presc == PRESC_LAST) begin
        presc_n = '0;
        count_n = count_dec;
        if (dec_zero) begin
          state_n   = ST_DONE;
          expired_n = 1'b1;
        end
      end else begin
        presc_n = presc + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      presc   <= presc_n;
      running <= (state_n == ST_RUN);
      done    <= (state_n == ST_DONE);
      expired <= expired_n;
    end
  end

  assign min_bcd = {count.min_hi, count.min_lo};
  assign sec_bcd = {count.sec_hi, count.sec_lo};

`ifdef TICK_COUNTDOWN_WARN_EN
  logic warn_q;
  always_ff @(posedge clock) begin
    if (reset) warn_q <= 1'b0;
    else warn_q <= ((state_n == ST_RUN) || (state_n == ST_PAUSE)) &&
                   ({count_n.min_hi, count_n.min_lo} == 8'h00) &&
                   ({count_n.sec_hi, count_n.sec_lo} <= WARN_THRESH);
  end
  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

endmodule
